// File: rtl/bcd2bin_time_pkg.sv
// Shared constants, state encoding and BCD helpers for the time-preset converter.
package bcd2bin_time_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CHECK   = 2'd1,
    S_CONVERT = 2'd2,
    S_FINISH  = 2'd3
  } state_e;

  localparam int CONVERT_STEPS = 7;
  localparam int MINUTE_MAX    = 59;
  localparam int SECOND_MAX    = 59;
  localparam int DIGIT_MAX     = 9;

  // Decimal value of a tens/ones digit pair; only meaningful when both digits are legal.
  function automatic int pair_val(input logic [7:0] p);
    return int'(p[7:4]) * 10 + int'(p[3:0]);
  endfunction

  function automatic logic digits_ok(input logic [31:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (int'(v[4*i +: 4]) > DIGIT_MAX) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/bcd2bin_time_pair.sv
// One digit-pair lane: reverse double-dabble, one shift/correct step per enabled cycle.
// bin_nxt_o is the result after the step in progress, so the caller can capture it on the last step.
module bcd_pair2bin (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       load_i,
  input  logic       step_i,
  input  logic [7:0] bcd_i,
  output logic [6:0] bin_nxt_o
);

  logic [7:0] bcd_q, bcd_d, shifted;
  logic [6:0] bin_q, bin_d;

  always_comb begin
    shifted = {1'b0, bcd_q[7:1]};
    bin_d   = {bcd_q[0], bin_q[6:1]};
    bcd_d   = shifted;
    if (shifted[3:0] >= 4'd8) bcd_d[3:0] = shifted[3:0] - 4'd3;
    if (shifted[7:4] >= 4'd8) bcd_d[7:4] = shifted[7:4] - 4'd3;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      bcd_q <= '0;
      bin_q <= '0;
    end else if (load_i) begin
      bcd_q <= bcd_i;
      bin_q <= '0;
    end else if (step_i) begin
      bcd_q <= bcd_d;
      bin_q <= bin_d;
    end
  end

  assign bin_nxt_o = bin_d;

endmodule

// File: rtl/bcd2bin_time.sv
// Validates a packed BCD hh:mm:ss.cc preset and converts it to binary in 10 cycles.
// Four parallel digit-pair lanes; the FSM, step counter and registered outputs live here.
module bcd2bin_time
  import bcd2bin_time_pkg::*;
#(
  parameter int HOUR_MAX = 23
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] bcd_in,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [5:0]  hour,
  output logic [5:0]  minute,
  output logic [5:0]  second,
  output logic [6:0]  m_sec
);

  state_e      state_q;
  logic [31:0] bcd_q;
  logic [2:0]  step_cnt_q;
  logic        busy_q, done_q, error_q;
  logic [5:0]  hour_q, minute_q, second_q;
  logic [6:0]  m_sec_q;
  logic        bad_d, load_d, step_d, last_step_d;
  logic [6:0]  lane_nxt [4];

  always_comb begin
    bad_d = !digits_ok(bcd_q)
         || (pair_val(bcd_q[31:24]) > HOUR_MAX)
         || (pair_val(bcd_q[23:16]) > MINUTE_MAX)
         || (pair_val(bcd_q[15:8])  > SECOND_MAX);
    load_d      = (state_q == S_CHECK) && !bad_d;
    step_d      = (state_q == S_CONVERT);
    last_step_d = step_d && (step_cnt_q == 3'(CONVERT_STEPS - 1));
  end

  // Lane 3 = hours ... lane 0 = centiseconds.
  for (genvar g = 0; g < 4; g++) begin : g_lane
    bcd_pair2bin u_lane (
      .clock_i   (clock),
      .reset_i   (reset),
      .load_i    (load_d),
      .step_i    (step_d),
      .bcd_i     (bcd_q[8*g +: 8]),
      .bin_nxt_o (lane_nxt[g])
    );
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      bcd_q      <= '0;
      step_cnt_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      hour_q     <= '0;
      minute_q   <= '0;
      second_q   <= '0;
      m_sec_q    <= '0;
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            bcd_q   <= bcd_in;
            busy_q  <= 1'b1;
            state_q <= S_CHECK;
          end
        end
        S_CHECK: begin
          step_cnt_q <= '0;
          if (bad_d) begin
            error_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            state_q <= S_CONVERT;
          end
        end
        S_CONVERT: begin
          step_cnt_q <= step_cnt_q + 3'd1;
          if (last_step_d) begin
            hour_q   <= lane_nxt[3][5:0];
            minute_q <= lane_nxt[2][5:0];
            second_q <= lane_nxt[1][5:0];
            m_sec_q  <= lane_nxt[0];
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= S_FINISH;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign error  = error_q;
  assign hour   = hour_q;
  assign minute = minute_q;
  assign second = second_q;
  assign m_sec  = m_sec_q;

endmodule

// File: tb/tb_bcd2bin_time.sv
// Scoreboard bench for bcd2bin_time: directed requests push expected responses,
// an independent monitor pops and compares on every done/error pulse.
module tb_bcd2bin_time;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] bcd_in = '0;
  logic        busy, done, error;
  logic [5:0]  hour, minute, second;
  logic [6:0]  m_sec;

  typedef struct {
    bit is_err;
    int k;
    int h, m, s, ms;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   lh = 0, lm = 0, ls = 0, lms = 0;

  bcd2bin_time #(.HOUR_MAX(23)) dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .bcd_in (bcd_in),
    .busy   (busy),
    .done   (done),
    .error  (error),
    .hour   (hour),
    .minute (minute),
    .second (second),
    .m_sec  (m_sec)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every output pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (done || error) begin
      chk("done_error_exclusive", int'(done && error), 0);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got done=%0d error=%0d expected none (cycle %0d)",
                 done, error, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("pulse_kind_error", int'(error), int'(e.is_err));
        chk("pulse_latency", cyc - e.k, e.is_err ? 1 : 8);
        chk("busy_at_pulse", int'(busy), 0);
        chk("hour", int'(hour), e.h);
        chk("minute", int'(minute), e.m);
        chk("second", int'(second), e.s);
        chk("m_sec", int'(m_sec), e.ms);
      end
    end
  end

  // Issue one request; good requests update the bench's own copy of the outputs.
  task automatic req(input logic [31:0] v, input bit is_err, input int h, input int m,
                     input int s, input int ms);
    exp_t e;
    @(negedge clock);
    start  = 1'b1;
    bcd_in = v;
    if (!is_err) begin
      lh = h; lm = m; ls = s; lms = ms;
    end
    e = '{is_err: is_err, k: cyc + 1, h: lh, m: lm, s: ls, ms: lms};
    sb.push_back(e);
    @(negedge clock);
    start = 1'b0;
    chk("busy_after_start", int'(busy), 1);
  endtask

  task automatic drain(input int n);
    repeat (n) @(negedge clock);
    chk("scoreboard_drained", sb.size(), 0);
  endtask

  initial begin
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_error", int'(error), 0);
    chk("reset_outputs", int'(hour) + int'(minute) + int'(second) + int'(m_sec), 0);
    reset = 1'b0;

    req(32'h12345678, 1'b0, 12, 34, 56, 78);  drain(12);
    req(32'h23595999, 1'b0, 23, 59, 59, 99);  drain(12);
    req(32'h24000000, 1'b1, 0, 0, 0, 0);      drain(12);
    req(32'h0000000A, 1'b1, 0, 0, 0, 0);      drain(12);
    req(32'h00600000, 1'b1, 0, 0, 0, 0);      drain(12);
    req(32'h00006000, 1'b1, 0, 0, 0, 0);      drain(12);
    req(32'hA0000000, 1'b1, 0, 0, 0, 0);      drain(12);
    req(32'h00000000, 1'b0, 0, 0, 0, 0);      drain(12);

    // A start while busy must not disturb the latched operand.
    req(32'h01020304, 1'b0, 1, 2, 3, 4);
    repeat (3) @(negedge clock);
    start  = 1'b1;
    bcd_in = 32'h09090909;
    @(negedge clock);
    start = 1'b0;
    drain(12);

    // Reset in the middle of CONVERT aborts silently and clears the outputs.
    req(32'h12345678, 1'b0, 12, 34, 56, 78);
    repeat (4) @(negedge clock);
    reset = 1'b1;
    start = 1'b1;
    sb.delete();
    lh = 0; lm = 0; ls = 0; lms = 0;
    @(negedge clock);
    reset = 1'b0;
    start = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_outputs", int'(hour) + int'(minute) + int'(second) + int'(m_sec), 0);
    drain(12);
    chk("abort_stays_idle", int'(busy), 0);

    req(32'h07080910, 1'b0, 7, 8, 9, 10);     drain(12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/bcd2bin_time.md
BCD2BIN_TIME -- requirements
Module: bcd2bin_time

Interface
REQ-001 SHALL have parameter HOUR_MAX, default 23, meaning the largest hour value accepted (legal range 1..63).
REQ-002 SHALL have port clock, input, 1, the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port start, input, 1, request to convert the value on bcd_in.
REQ-005 SHALL have port bcd_in, input, 32, BCD digits packed [31:28] hour tens, [27:24] hour ones, [23:20] minute tens, [19:16] minute ones, [15:12] second tens, [11:8] second ones, [7:4] centisecond tens, [3:0] centisecond ones.
REQ-006 SHALL have port busy, output, 1, high while a request is in progress.
REQ-007 SHALL have port done, output, 1, one-cycle pulse on a successful conversion.
REQ-008 SHALL have port error, output, 1, one-cycle pulse on a rejected request.
REQ-009 SHALL have ports hour (6), minute (6), second (6) and m_sec (7), all outputs, holding the binary time preset for loading the stopwatch.

Function
REQ-010 SHALL implement states IDLE, CHECK, CONVERT and FINISH.
REQ-011 In IDLE, with start high at edge k, SHALL latch bcd_in and enter CHECK; busy SHALL be high from cycle k+1.
REQ-012 SHALL ignore start in every state other than IDLE; the latched operand SHALL NOT change.
REQ-013 CHECK (one cycle) SHALL flag an error when any digit is >9, hour >HOUR_MAX, minute >59 or second >59.
REQ-014 On an error, CHECK SHALL pulse error in cycle k+2, return to IDLE, and leave hour/minute/second/m_sec unchanged.
REQ-015 Otherwise CHECK SHALL enter CONVERT, which SHALL run exactly 7 cycles (cycles k+2..k+8).
REQ-016 CONVERT SHALL use a reverse double-dabble on all four digit pairs in parallel:
 - per cycle: shift pair right 1 bit into its result register;
 - then subtract 3 from each BCD digit that is >=8.
REQ-017 After the 7th CONVERT cycle, FINISH SHALL apply for cycle k+9: outputs updated from the 7-bit results (hour/minute/second take the low 6 bits), done=1, busy=0, then return to IDLE.
REQ-018 A new start SHALL be accepted in FINISH's following IDLE cycle (k+10) at the earliest; throughput 1 request per 10 cycles.
REQ-019 done and error SHALL never be high together; each SHALL be high for exactly one cycle per request.
REQ-020 Boundary values 00:00:00.00 and HOUR_MAX:59:59.99 SHALL convert without error.
REQ-021 Result registers SHALL be 7 bits wide with no overflow; a legal pair never exceeds 99.

Reset
REQ-022 reset high at any edge SHALL force IDLE, busy=0, done=0, error=0, and hour=minute=second=m_sec=0.
REQ-023 reset SHALL abort any request in progress with no done or error pulse; reset SHALL take priority over start in the same cycle.

Structure
REQ-024 The shared package SHALL hold the state encoding, CONVERT_STEPS=7, MINUTE_MAX=59, SECOND_MAX=59 and DIGIT_MAX=9.
REQ-025 SHALL instantiate four copies of sub-module bcd_pair2bin (one 8-bit BCD shift/correct lane with load and step enables); the FSM and step counter SHALL live in the top.

Verification
REQ-026 start with bcd_in=0x12345678 at edge k -> busy for k+1..k+8; done in k+9; hour=12, minute=34, second=56, m_sec=78.
REQ-027 bcd_in=0x23595999 -> done; outputs 23, 59, 59, 99.
REQ-028 After a good conversion, bcd_in=0x24000000 -> error in k+2 only; outputs keep their previous values; done stays 0.
REQ-029 bcd_in=0x0000000A (illegal digit) -> error in k+2; bcd_in=0x00600000 (minute 60) -> error.
REQ-030 start=0x01020304, then start=0x09090909 at k+4 -> second request ignored; outputs 1, 2, 3, 4 at k+9.
REQ-031 reset at k+5 mid-CONVERT -> next cycle idle, all outputs 0, no done; a fresh start then completes normally.
